// File: rtl/soc_bb_dma.sv
// Single-channel Blackbone DMA: word-by-word copy from src to dst, holding the bus for the whole transfer.
// Optional fill mode (constant pattern to dst) is compiled in with SOC_BB_DMA_FILL_EN.
module soc_bb_dma #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] cfg_src_i,
    input  logic [ADDR_WIDTH-1:0] cfg_dst_i,
    input  logic [LEN_WIDTH-1:0]  cfg_len_i,
`ifdef SOC_BB_DMA_FILL_EN
    input  logic                  cfg_fill_i,
    input  logic [DATA_WIDTH-1:0] cfg_pattern_i,
`endif
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  bus_hold_o,
    input  logic                  bus_hold_ack_i,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [DATA_WIDTH-1:0] m_din_o,
    output logic                  m_en_o,
    output logic                  m_we_o,
    input  logic [DATA_WIDTH-1:0] m_dout_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_fill;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [DATA_WIDTH-1:0] r_din_q;

    logic                  w_fill_start;
    logic [DATA_WIDTH-1:0] w_pattern;
    logic [LEN_WIDTH-1:0]  w_len_nxt;

`ifdef SOC_BB_DMA_FILL_EN
    assign w_fill_start = cfg_fill_i;
    assign w_pattern    = cfg_pattern_i;
`else
    assign w_fill_start = 1'b0;
    assign w_pattern    = '0;
`endif

    assign w_len_nxt = r_len - LEN_WIDTH'(1);

    // r_addr_q / r_din_q remember the last values put on the bus so they hold between accesses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= IDLE;
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_data   <= '0;
            r_fill   <= 1'b0;
            r_addr_q <= '0;
            r_din_q  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        if (cfg_len_i != '0) begin
                            r_src   <= cfg_src_i;
                            r_dst   <= cfg_dst_i;
                            r_len   <= cfg_len_i;
                            r_fill  <= w_fill_start;
                            if (w_fill_start) begin
                                r_data <= w_pattern;
                            end
                            r_state <= HOLD;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                HOLD: begin
                    if (bus_hold_ack_i) begin
                        r_state <= r_fill ? WRITE : READ;
                    end
                end
                READ: begin
                    r_addr_q <= r_src;
                    if (bus_hold_ack_i) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_data  <= m_dout_i;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_addr_q <= r_dst;
                    r_din_q  <= r_data;
                    if (bus_hold_ack_i) begin
                        r_src <= r_src + STRIDE;
                        r_dst <= r_dst + STRIDE;
                        r_len <= w_len_nxt;
                        if (w_len_nxt == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= r_fill ? WRITE : READ;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = (r_state != IDLE);
    assign done_o     = (r_state == DONE);
    assign bus_hold_o = (r_state == HOLD) || (r_state == READ) ||
                        (r_state == CAPTURE) || (r_state == WRITE);

    // Enables follow the grant combinationally so a dropped ack stalls the access in the same cycle.
    always_comb begin
        m_en_o   = 1'b0;
        m_we_o   = 1'b0;
        m_addr_o = r_addr_q;
        m_din_o  = r_din_q;
        case (r_state)
            READ: begin
                m_en_o   = bus_hold_ack_i;
                m_addr_o = r_src;
            end
            WRITE: begin
                m_en_o   = bus_hold_ack_i;
                m_we_o   = 1'b1 & bus_hold_ack_i;
                m_addr_o = r_dst;
                m_din_o  = r_data;
            end
            default: begin
                m_en_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_soc_bb_dma.sv
// Randomized self-checking bench for soc_bb_dma against a transaction-level copy/fill model.
module tb_soc_bb_dma;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cfg_src, cfg_dst;
    logic [LW-1:0] cfg_len;
    logic          cfg_fill;
    logic [DW-1:0] cfg_pattern;
    logic          start, ack;
    logic          busy, done, hold, m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, m_dout;

    int errors = 0;
    int checks = 0;
    logic [31:0] key;

    always #5 clk = ~clk;

    soc_bb_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .cfg_src_i(cfg_src),
        .cfg_dst_i(cfg_dst),
        .cfg_len_i(cfg_len),
`ifdef SOC_BB_DMA_FILL_EN
        .cfg_fill_i(cfg_fill),
        .cfg_pattern_i(cfg_pattern),
`endif
        .start_i(start),
        .busy_o(busy),
        .done_o(done),
        .bus_hold_o(hold),
        .bus_hold_ack_i(ack),
        .m_addr_o(m_addr),
        .m_din_o(m_din),
        .m_en_o(m_en),
        .m_we_o(m_we),
        .m_dout_i(m_dout)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory contents seen by the DMA: a keyed hash of the byte address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ key;
    endfunction

    // mode 0: grant always high, 1: random grant and random start/cfg noise while busy,
    // 2: grant dropped in cycles 4..6 (the first WRITE of a copy). exp_done < 0 skips timing.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int mode, input bit fill, input logic [31:0] pat,
                            input int exp_done);
        logic [31:0] rd_q[$];
        logic [31:0] wa_q[$];
        logic [31:0] wd_q[$];
        int          wc_q[$];
        int          done_cyc;
        int          hold_cyc;
        bit          prev_rd;
        logic [31:0] e_s, e_d;
        done_cyc = -1;
        hold_cyc = 0;
        prev_rd  = 1'b0;
        key      = $urandom;
        @(negedge clk);
        cfg_src     = src;
        cfg_dst     = dst;
        cfg_len     = LW'(len);
        cfg_fill    = fill;
        cfg_pattern = pat;
        start       = 1'b1;
        ack         = 1'b1;
        #1;
        check_val("idle_busy", busy, 0);
        for (int c = 1; c < 400 && done_cyc < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mode == 1) begin
                start       = 1'($urandom_range(0, 1));
                cfg_src     = $urandom;
                cfg_dst     = $urandom;
                cfg_len     = LW'($urandom_range(0, 9));
                cfg_fill    = 1'($urandom_range(0, 1));
                cfg_pattern = $urandom;
                ack         = ($urandom_range(0, 3) != 0);
            end else if (mode == 2) begin
                ack = !(c >= 4 && c <= 6);
            end else begin
                ack = 1'b1;
            end
            if (!prev_rd) m_dout = $urandom;
            #1;
            prev_rd = 1'b0;
            if (m_en && !m_we) begin
                rd_q.push_back(m_addr);
                m_dout  = mem_f(m_addr);
                prev_rd = 1'b1;
            end
            if (m_en && m_we) begin
                wa_q.push_back(m_addr);
                wd_q.push_back(m_din);
                wc_q.push_back(c);
            end
            check_val("hold_rule", hold, busy & ~done);
            check_val("en_needs_ack", m_en & ~ack, 0);
            if (hold) hold_cyc++;
            if (done) done_cyc = c;
        end
        start = 1'b0;
        check_val("done_seen", (done_cyc >= 0), 1);
        if (exp_done >= 0) check_val("done_cycle", done_cyc, exp_done);
        if (len == 0) check_val("len0_hold_cycles", hold_cyc, 0);
        check_val("n_writes", wa_q.size(), len);
        check_val("n_reads", rd_q.size(), fill ? 0 : len);
        for (int k = 0; k < len; k++) begin
            e_s = src + 32'(4 * k);
            e_d = dst + 32'(4 * k);
            if (!fill && k < rd_q.size()) check_val("rd_addr", rd_q[k], e_s);
            if (k < wa_q.size()) begin
                check_val("wr_addr", wa_q[k], e_d);
                check_val("wr_data", wd_q[k], fill ? pat : mem_f(e_s));
            end
            if (fill && k > 0 && k < wc_q.size()) check_val("fill_back2back", wc_q[k], wc_q[k-1] + 1);
        end
        @(negedge clk);
        #1;
        check_val("done_one_cycle", done, 0);
        check_val("idle_after_done", busy, 0);
    endtask

    initial begin
        int act;
        rst_n       = 1'b0;
        cfg_src     = '0;
        cfg_dst     = '0;
        cfg_len     = '0;
        cfg_fill    = 1'b0;
        cfg_pattern = '0;
        start       = 1'b0;
        ack         = 1'b0;
        m_dout      = '0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_hold", hold, 0);
        check_val("rst_en", m_en, 0);
        check_val("rst_addr", m_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_xfer(32'h100, 32'h200, 4, 0, 1'b0, 32'h0, 14);
        run_xfer(32'h180, 32'h280, 0, 0, 1'b0, 32'h0, 1);
        run_xfer(32'h300, 32'h400, 2, 2, 1'b0, 32'h0, 11);
        run_xfer(32'hFFFF_FFFC, 32'h500, 2, 0, 1'b0, 32'h0, 8);

        // Reset in CAPTURE of word 1 of an 8-word copy (cycle 6 after start).
        @(negedge clk);
        cfg_src  = 32'h100;
        cfg_dst  = 32'h900;
        cfg_len  = LW'(8);
        cfg_fill = 1'b0;
        start    = 1'b1;
        ack      = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check_val("pre_rst_capture_en", m_en, 0);
        check_val("pre_rst_capture_hold", hold, 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        check_val("midrst_hold", hold, 0);
        check_val("midrst_en", m_en, 0);
        check_val("midrst_we", m_we, 0);
        check_val("midrst_addr", m_addr, 0);
        check_val("midrst_din", m_din, 0);
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            act += int'(m_en) + int'(busy) + int'(hold);
        end
        check_val("no_resume_after_rst", act, 0);

        for (int t = 0; t < 6; t++) begin
            run_xfer($urandom, $urandom, $urandom_range(1, 6), 1, 1'b0, 32'h0, -1);
        end

`ifdef SOC_BB_DMA_FILL_EN
        run_xfer(32'h0, 32'h40, 3, 0, 1'b1, 32'hA5A5_A5A5, 5);
        run_xfer($urandom, $urandom, $urandom_range(1, 5), 0, 1'b1, $urandom, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/soc_bb_dma.md
SOC_BB_DMA -- requirements
Module: soc_bb_dma

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of Blackbone address and of source/destination registers.
REQ-002 Parameter DATA_WIDTH, default 32, Blackbone data width; SHALL be a multiple of 8.
REQ-003 Parameter LEN_WIDTH, default 16, width of the word-count register.
REQ-004 clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-low.
REQ-006 cfg_src_i, cfg_dst_i  input  ADDR_WIDTH each  source and destination byte addresses, sampled on accepted start.
REQ-007 cfg_len_i  input  LEN_WIDTH  number of words to copy, sampled on accepted start.
REQ-008 start_i  input  1  transfer request; accepted only in IDLE.
REQ-009 busy_o  output  1  high in every state except IDLE.
REQ-010 done_o  output  1  single-cycle completion pulse.
REQ-011 bus_hold_o  output  1  request for exclusive Blackbone ownership.
REQ-012 bus_hold_ack_i  input  1  ownership grant from the interconnect.
REQ-013 m_addr_o  output  ADDR_WIDTH  Blackbone address.
REQ-014 m_din_o  output  DATA_WIDTH  Blackbone write data.
REQ-015 m_en_o, m_we_o  output  1 each  Blackbone enable and write-enable.
REQ-016 m_dout_i  input  DATA_WIDTH  Blackbone read data, valid one cycle after a read enable.

Function
REQ-017 FSM states SHALL be IDLE, HOLD, READ, CAPTURE, WRITE, DONE.
REQ-018 IDLE: start_i=1 with cfg_len_i!=0 latches src, dst, len and goes to HOLD; start_i=1 with cfg_len_i=0 goes to DONE without asserting bus_hold_o.
REQ-019 start_i outside IDLE SHALL be ignored; configuration inputs are not re-sampled.
REQ-020 bus_hold_o SHALL be high in HOLD, READ, CAPTURE, WRITE and low otherwise.
REQ-021 HOLD: go to READ on the first cycle bus_hold_ack_i=1.
REQ-022 READ: m_en_o=bus_hold_ack_i, m_we_o=0, m_addr_o=src; advance to CAPTURE only when bus_hold_ack_i=1, else remain in READ with no enable.
REQ-023 CAPTURE: m_en_o=0; data register loads m_dout_i; go to WRITE.
REQ-024 WRITE: m_en_o=bus_hold_ack_i, m_we_o=1, m_addr_o=dst, m_din_o=data register; on bus_hold_ack_i=1 src and dst increment by DATA_WIDTH/8, len decrements, next state READ if new len!=0 else DONE; with ack low remain in WRITE with no enable.
REQ-025 Address increments SHALL wrap modulo 2^ADDR_WIDTH without error.
REQ-026 Throughput with continuous grant SHALL be exactly 3 cycles per word (READ, CAPTURE, WRITE).
REQ-027 DONE: done_o=1 for exactly one cycle, bus_hold_o=0; next state IDLE.
REQ-028 m_en_o, m_we_o SHALL be 0 in IDLE, HOLD, CAPTURE, DONE; m_addr_o, m_din_o hold last driven values when not enabled.

Reset
REQ-029 Reset assertion SHALL immediately force IDLE, busy_o=0, done_o=0, bus_hold_o=0, m_en_o=0, m_we_o=0, m_addr_o=0, m_din_o=0, and clear src, dst, len, data registers, including mid-transfer.
REQ-030 After reset release no transfer SHALL resume; a new start_i is required.

Configuration
REQ-031 With macro SOC_BB_DMA_FILL_EN defined, input cfg_fill_i (1) and cfg_pattern_i (DATA_WIDTH) SHALL exist; a start with cfg_fill_i=1 latches cfg_pattern_i into the data register and the FSM loops HOLD->WRITE->WRITE..., skipping READ/CAPTURE, 1 cycle per word, src unused.
REQ-032 Without SOC_BB_DMA_FILL_EN, those ports SHALL be absent and every transfer is a copy.

Verification
REQ-033 src=0x100, dst=0x200, len=4, ack tied high -> reads 0x100,0x104,0x108,0x10C then writes to 0x200..0x20C with returned data, done_o pulse 12 cycles after HOLD exit + 1.
REQ-034 len=0 start -> done_o pulse next cycle, bus_hold_o never asserted, no m_en_o.
REQ-035 len=2, ack dropped for 3 cycles during WRITE of word 0 -> m_en_o low those cycles, write issued once after ack returns, data unchanged, total 2 writes.
REQ-036 src=0xFFFFFFFC, len=2 -> second read address 0x00000000.
REQ-037 reset asserted in CAPTURE of word 1 of len=8 -> all outputs zero same cycle, no further bus activity after release until new start_i.
REQ-038 (SOC_BB_DMA_FILL_EN) fill, dst=0x40, len=3, pattern=0xA5A5A5A5 -> writes 0x40,0x44,0x48 on consecutive cycles, no reads.
